// File: rtl/gmem_pkg.sv
// rtl/gmem_pkg.sv - shared GMEM framebuffer constants and blitter state type
//
// Shared by the scan-out reader and all GMEM writers.
//   FB_W, FB_H   : framebuffer dimensions in pixels (1 bpp)
//   GMEM_ADDR_W  : GMEM address width
//   SPR_DIM      : sprite edge length in pixels
//   blit_state_t : sprite blitter FSM states

package gmem_pkg;

   localparam int FB_W        = 160;
   localparam int FB_H        = 120;
   localparam int GMEM_ADDR_W = 17;
   localparam int SPR_DIM     = 8;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      WRITE,
      DONE
   } blit_state_t;

endpackage

// File: rtl/blit_addr_gen.sv
// rtl/blit_addr_gen.sv - combinational GMEM pixel address and clip flag
//
// Ports:
//   pos_x, pos_y : object top-left corner in framebuffer pixels
//   row, col     : pixel offset inside the 8x8 object
//   base_addr    : frame base offset
//   addr         : (px + FB_W*py + base_addr) mod 2^ADDR_W
//   in_bounds    : px < FB_W and py < FB_H (pixel lies on screen)

module blit_addr_gen #(
   parameter int FB_W   = gmem_pkg::FB_W,
   parameter int FB_H   = gmem_pkg::FB_H,
   parameter int ADDR_W = gmem_pkg::GMEM_ADDR_W
) (
   input  logic [7:0]        pos_x,
   input  logic [6:0]        pos_y,
   input  logic [2:0]        row,
   input  logic [2:0]        col,
   input  logic [ADDR_W-1:0] base_addr,
   output logic [ADDR_W-1:0] addr,
   output logic              in_bounds
);

   logic [8:0] px;
   logic [7:0] py;

   // One extra bit on each coordinate so off-screen pixels clip instead of wrapping.
   assign px = {1'b0, pos_x} + {6'b0, col};
   assign py = {1'b0, pos_y} + {5'b0, row};

   assign addr      = ADDR_W'(px) + ADDR_W'(FB_W) * ADDR_W'(py) + base_addr;
   assign in_bounds = (32'(px) < FB_W) && (32'(py) < FB_H);

endmodule

// File: rtl/gmem_blitter.sv
// rtl/gmem_blitter.sv - 8x8 1-bpp sprite blitter into the GMEM framebuffer
//
// Optional feature macro: GMEM_BLIT_TRANSPARENT_EN (0-pixels after invert are not written).
//
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   start                 : draw request, accepted only in IDLE
//   spr_idx, pos_x, pos_y : sprite index and top-left position
//   base_addr, invert     : frame base offset, pixel XOR
//   busy, done            : blit in progress, one-cycle completion pulse
//   spr_addr, spr_data    : sprite ROM port {idx,row}, 1-cycle read latency
//   gmem_addr, gmem_data  : GMEM write address and pixel
//   gmem_wEn              : GMEM write enable

module gmem_blitter #(
   parameter int FB_W      = gmem_pkg::FB_W,
   parameter int FB_H      = gmem_pkg::FB_H,
   parameter int ADDR_W    = gmem_pkg::GMEM_ADDR_W,
   parameter int SPR_IDX_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [SPR_IDX_W-1:0] spr_idx,
   input  logic [7:0]           pos_x,
   input  logic [6:0]           pos_y,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic                 invert,
   output logic                 busy,
   output logic                 done,
   output logic [SPR_IDX_W+2:0] spr_addr,
   input  logic [7:0]           spr_data,
   output logic [ADDR_W-1:0]    gmem_addr,
   output logic                 gmem_data,
   output logic                 gmem_wEn
);

   import gmem_pkg::*;

   blit_state_t state, state_nxt;

   logic [SPR_IDX_W-1:0] idx_q;
   logic [7:0]           x_q;
   logic [6:0]           y_q;
   logic [ADDR_W-1:0]    base_q;
   logic                 inv_q;
   logic [2:0]           row;
   logic [2:0]           col;
   logic [7:0]           shreg;

   logic [ADDR_W-1:0]    addr;
   logic                 in_bounds;
   logic                 pix;
   logic                 last_col;

   blit_addr_gen #(
      .FB_W   (FB_W),
      .FB_H   (FB_H),
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .pos_x     (x_q),
      .pos_y     (y_q),
      .row       (row),
      .col       (col),
      .base_addr (base_q),
      .addr      (addr),
      .in_bounds (in_bounds)
   );

   // Row shift register is consumed MSB first: bit 7 is always the current column's pixel.
   assign pix      = shreg[7] ^ inv_q;
   assign last_col = (col == 3'(SPR_DIM - 1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         idx_q  <= '0;
         x_q    <= '0;
         y_q    <= '0;
         base_q <= '0;
         inv_q  <= 1'b0;
         row    <= '0;
         col    <= '0;
         shreg  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  idx_q  <= spr_idx;
                  x_q    <= pos_x;
                  y_q    <= pos_y;
                  base_q <= base_addr;
                  inv_q  <= invert;
                  row    <= '0;
                  col    <= '0;
               end
            end
            WAIT: shreg <= spr_data;
            WRITE: begin
               shreg <= {shreg[6:0], 1'b0};
               col   <= col + 3'd1;
               if (last_col) begin
                  row <= row + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      spr_addr  = '0;
      gmem_addr = '0;
      gmem_data = 1'b0;
      gmem_wEn  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = FETCH;
            end
         end
         FETCH: begin
            busy      = 1'b1;
            spr_addr  = {idx_q, row};
            state_nxt = WAIT;
         end
         WAIT: begin
            busy      = 1'b1;
            state_nxt = WRITE;
         end
         WRITE: begin
            busy      = 1'b1;
            gmem_addr = addr;
            gmem_data = pix;
            // Gated by reset so the write is suppressed in the cycle reset is sampled.
`ifdef GMEM_BLIT_TRANSPARENT_EN
            gmem_wEn  = in_bounds & pix & reset;
`else
            gmem_wEn  = in_bounds & reset;
`endif
            if (last_col) begin
               state_nxt = (row == 3'(SPR_DIM - 1)) ? DONE : FETCH;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: doc/gmem_blitter.md
# gmem_blitter

Sprite blitter that writes 8x8 1-bpp sprites from a sprite ROM into the 160x120 1-bpp graphics framebuffer (GMEM) read by the VGA scan-out path. It sits between the game logic, which issues draw requests, and the GMEM write port. It performs per-pixel clipping against the 160x120 screen and adds a frame-base offset, so it can draw into either stored frame.

## Interface
Parameters:
- FB_W, 160, framebuffer width in pixels
- FB_H, 120, framebuffer height in pixels
- ADDR_W, 17, GMEM address width
- SPR_IDX_W, 8, sprite index width (ROM holds 2^SPR_IDX_W sprites)

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset)
- start  input  1  draw request; accepted only in IDLE
- spr_idx  input  SPR_IDX_W  sprite to draw
- pos_x  input  8  sprite left column in framebuffer pixels
- pos_y  input  7  sprite top row in framebuffer pixels
- base_addr  input  ADDR_W  frame base offset added to every address
- invert  input  1  XOR applied to sprite bits before writing
- busy  output  1  high while a blit is in progress
- done  output  1  one-cycle pulse when a blit completes
- spr_addr  output  SPR_IDX_W+3  sprite ROM address = {spr_idx, row[2:0]}
- spr_data  input  8  sprite ROM row; bit 7 = leftmost pixel; valid 1 cycle after spr_addr
- gmem_addr  output  ADDR_W  GMEM write address
- gmem_data  output  1  GMEM write data
- gmem_wEn  output  1  GMEM write enable

## Operation
- FSM states: IDLE, FETCH, WAIT, WRITE, DONE.
- IDLE: if start, latch spr_idx, pos_x, pos_y, base_addr and invert; clear row and col; go to FETCH.
- FETCH: drive spr_addr = {idx, row}; go to WAIT.
- WAIT: on the ROM data edge, capture spr_data into the row shift register; go to WRITE.
- WRITE: one pixel per cycle, col 0..7.
  - px = pos_x + col, 9-bit unsigned; py = pos_y + row, 8-bit unsigned.
  - gmem_addr = px + FB_W*py + base_addr, truncated mod 2^ADDR_W.
  - gmem_data = bit[7-col] ^ invert.
  - gmem_wEn = 1 only if px < FB_W and py < FB_H.
  - The shape is clipped, not wrapped.
  - After col 7: if row == 7 go to DONE, else increment row and go to FETCH.
- DONE: done = 1 for one cycle; go to IDLE.
- start in any state other than IDLE is ignored. It is not queued.
- Latched inputs are immune to input changes during a blit.
- Reset active in any state: next state IDLE; row/col cleared; all outputs 0. No write occurs in the cycle reset is sampled.

## Timing
- Reset values: busy=0, done=0, gmem_wEn=0, gmem_addr=0, gmem_data=0, spr_addr=0.
- start sampled high in IDLE at edge N: busy=1 from cycle N+1.
- Each row takes 10 cycles (FETCH 1, WAIT 1, WRITE 8). A full blit keeps busy high for 80 cycles.
- done is high in cycle N+81 with busy=0. A new start is accepted in IDLE at the following edge at the earliest.
- gmem_* outputs are combinational from registered state, col, row and the shift register. They are valid for the whole WRITE cycle and 0 outside WRITE.
- spr_addr is valid in FETCH. The ROM has 1-cycle read latency.

## Configuration
- GMEM_BLIT_TRANSPARENT_EN defined:
  - A pixel whose post-invert value is 0 is not written (gmem_wEn=0).
  - Only 1-pixels overwrite the background.
  - Cycle count is unchanged.
- Undefined: all unclipped pixels are written, 0s included (opaque 8x8 block).

## Structure
- Shared package gmem_pkg:
  - FB_W, FB_H, GMEM_ADDR_W=17, SPR_DIM=8
  - blit_state_t enum (IDLE, FETCH, WAIT, WRITE, DONE)
  - Shared by the scan-out reader and any future GMEM writers.
- One sub-module: blit_addr_gen. It is combinational: from pos_x, pos_y, row, col and base_addr it produces gmem_addr and the in_bounds flag. It is reused for later tile writers.

## Test plan
- Sprite 0x01 is all-ones, pos (10,20), base 0, no invert: 64 writes; first addr 3210, last 4337; busy high for exactly 80 cycles; done one cycle later.
- Same sprite at pos (156,118): only 4x2=8 writes occur, the first at addr 19036 (156+160*118). No write has px>=160 or py>=120.
- base_addr=19200 with pos (0,0): first addr 19200. Then base_addr=131071 with pos (1,0): addr wraps to 0 mod 2^17.
- Sprite row 0xA5, invert=1: written data per col is 0,1,0,1,1,0,1,0. With GMEM_BLIT_TRANSPARENT_EN, only cols 1, 3, 4 and 6 assert gmem_wEn.
- start pulsed mid-blit, and start held high through DONE: no second blit until IDLE; exactly one done per accepted start.
- reset=0 asserted during WRITE of row 3: next cycle is IDLE, all outputs 0, no further writes; a subsequent start performs a full 64-pixel blit.
